// File: rtl/fma_sched_pkg.sv
// Shared types and helpers for the FMA sharing scheduler.
// The tag index is sized for up to 256 requesters; the top uses only the low bits.
package fma_sched_pkg;

    localparam int unsigned TAG_IDX_W = 8;

    typedef struct packed {
        logic                 v;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    // Signed zero only; denormals have a nonzero mantissa and are not zero.
    function automatic logic fp16_is_zero(input logic [15:0] x);
        return x[14:0] == 15'd0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the rotating pointer.
// The pointer moves just past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = IW'((32'(ptr_q) + i) % N);
            if (en && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (32'(idx) == N - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/fma_share_scheduler.sv
// Shares one pipelined FP16 FMA among NREQ requesters, tagging each in-flight
// op with its requester so the result is routed back in order.
module fma_share_scheduler
    import fma_sched_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned FP_W      = 16,
    parameter int unsigned LATENCY   = 1,
    parameter bit          ZERO_GATE = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_stall,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*FP_W-1:0] i_req_a,
    input  logic [NREQ*FP_W-1:0] i_req_b,
    input  logic [NREQ*FP_W-1:0] i_req_c,
    output logic [FP_W-1:0]      o_fma_a,
    output logic [FP_W-1:0]      o_fma_b,
    output logic [FP_W-1:0]      o_fma_c,
    output logic                 o_fma_msel,
    output logic                 o_fma_pipeline_en,
    input  logic [FP_W-1:0]      i_fma_result,
    output logic [NREQ-1:0]      o_rsp_valid,
    input  logic [NREQ-1:0]      i_rsp_ready,
    output logic [FP_W-1:0]      o_rsp_data,
    output logic                 o_busy
);

    localparam int unsigned IW = $clog2(NREQ);

    if (LATENCY < 1) begin : g_lat_chk
        $error("fma_share_scheduler: LATENCY must be >= 1");
    end
    if (NREQ < 2 || NREQ > (1 << TAG_IDX_W)) begin : g_nreq_chk
        $error("fma_share_scheduler: NREQ out of range");
    end

    tag_t            tag_q [LATENCY];
    tag_t            tail;
    tag_t            head;
    logic [IW-1:0]   tail_idx;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            blocked;
    logic            pipeline_en;
    logic            accept;

    assign tail     = tag_q[LATENCY-1];
    assign tail_idx = tail.idx[IW-1:0];

    if (IW < TAG_IDX_W) begin : g_unused_idx
        logic unused_tail_idx;
        assign unused_tail_idx = ^tail.idx[TAG_IDX_W-1:IW];
    end

    // A response the target cannot take freezes the whole pipe to keep order.
    assign blocked     = tail.v & ~i_rsp_ready[tail_idx];
    assign pipeline_en = ~i_stall & ~blocked;

    // No grants while reset is held, even though the pipe reports enabled.
    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .req   (i_req_valid),
        .en    (pipeline_en & i_rstn),
        .gnt   (gnt),
        .idx   (gnt_idx)
    );

    assign accept      = |gnt;
    assign o_req_ready = gnt;
    assign head        = '{v: accept, idx: TAG_IDX_W'(gnt_idx)};

    always_comb begin
        o_fma_a    = '0;
        o_fma_b    = '0;
        o_fma_c    = '0;
        o_fma_msel = ZERO_GATE;
        if (accept) begin
            o_fma_a    = i_req_a[gnt_idx*FP_W +: FP_W];
            o_fma_b    = i_req_b[gnt_idx*FP_W +: FP_W];
            o_fma_c    = i_req_c[gnt_idx*FP_W +: FP_W];
            o_fma_msel = ZERO_GATE &
                         (fp16_is_zero(16'(o_fma_a)) | fp16_is_zero(16'(o_fma_b)));
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_q[i] <= '0;
            end
        end else if (pipeline_en) begin
            tag_q[0] <= head;
            for (int i = 1; i < int'(LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            o_busy = o_busy | tag_q[i].v;
        end
    end

    assign o_fma_pipeline_en = pipeline_en;
    assign o_rsp_valid       = tail.v ? (NREQ'(1) << tail_idx) : '0;
    assign o_rsp_data        = i_fma_result;

endmodule

// File: tb/tb_fma_share_scheduler.sv
// Scoreboard bench for fma_share_scheduler with a behavioural FMA stub.
module tb_fma_share_scheduler;
    localparam int NREQ = 4;
    localparam int FP_W = 16;
    localparam int LAT  = 3;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] exp;
    } op_t;
    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 stall = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*FP_W-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic [FP_W-1:0]      fma_a, fma_b, fma_c, fma_result, rsp_data;
    logic                 msel, pen, busy;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready = '1;
    logic [NREQ-1:0]      unused_nz_ready, unused_nz_rsp_valid;
    logic [FP_W-1:0]      unused_nz_a, unused_nz_b, unused_nz_c, unused_nz_data;
    logic                 nz_msel, unused_nz_pen, unused_nz_busy;

    op_t  pend [NREQ][$];
    exp_t sb[$];
    int   total = 0, bad = 0;
    int   acc_cnt = 0, zg_hits = 0, cyc = 0;
    int   acc_log[$], acc_cyc[$];
    logic [NREQ-1:0] acc_vec = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fma_share_scheduler #(.NREQ(NREQ), .FP_W(FP_W), .LATENCY(LAT), .ZERO_GATE(1'b1)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_stall(stall), .i_req_valid(req_valid),
        .o_req_ready(req_ready), .i_req_a(req_a), .i_req_b(req_b), .i_req_c(req_c),
        .o_fma_a(fma_a), .o_fma_b(fma_b), .o_fma_c(fma_c), .o_fma_msel(msel),
        .o_fma_pipeline_en(pen), .i_fma_result(fma_result), .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_busy(busy));

    fma_share_scheduler #(.NREQ(NREQ), .FP_W(FP_W), .LATENCY(LAT), .ZERO_GATE(1'b0)) dut_nz (
        .i_clk(clk), .i_rstn(rstn), .i_stall(stall), .i_req_valid(req_valid),
        .o_req_ready(unused_nz_ready), .i_req_a(req_a), .i_req_b(req_b), .i_req_c(req_c),
        .o_fma_a(unused_nz_a), .o_fma_b(unused_nz_b), .o_fma_c(unused_nz_c),
        .o_fma_msel(nz_msel), .o_fma_pipeline_en(unused_nz_pen), .i_fma_result(fma_result),
        .o_rsp_valid(unused_nz_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(unused_nz_data), .o_busy(unused_nz_busy));

    // FMA stub: known vectors give true FP16 results, anything else a ^ b ^ c.
    function automatic logic [15:0] fake_fma(input logic [15:0] a, b, c);
        if (a == 16'h3C00 && b == 16'h4000 && c == 16'h4200) return 16'h4500;
        if (a == 16'h8000 && b == 16'h4000 && c == 16'h4680) return 16'h4680;
        return a ^ b ^ c;
    endfunction

    logic [15:0] fpipe [LAT];
    always @(posedge clk) begin
        if (pen) begin
            fpipe[0] <= fake_fma(fma_a, fma_b, fma_c);
            for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
        end
    end
    assign fma_result = fpipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [15:0] a, b, c, e);
        pend[r].push_back('{a: a, b: b, c: c, exp: e});
    endtask

    // Requester model: valid/operands come from each requester's queue head.
    initial begin : driver
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++)
                if (acc_vec[r] && pend[r].size() > 0) void'(pend[r].pop_front());
            acc_vec = '0;
            for (int r = 0; r < NREQ; r++) begin
                req_valid[r] = pend[r].size() > 0;
                if (pend[r].size() > 0) begin
                    req_a[r*FP_W +: FP_W] = pend[r][0].a;
                    req_b[r*FP_W +: FP_W] = pend[r][0].b;
                    req_c[r*FP_W +: FP_W] = pend[r][0].c;
                end
            end
        end
    end

    // Accept side: check FMA operands/msel and push the expected response.
    initial begin : acc_side
        logic [NREQ-1:0] acc;
        int g;
        op_t op;
        forever begin
            @(negedge clk);
            if (rstn) begin
                acc = req_valid & req_ready;
                chk("grant_onehot0", 64'($onehot0(req_ready)), 64'd1);
                if (acc != '0) begin
                    g = 0;
                    for (int r = 0; r < NREQ; r++) if (acc[r]) g = r;
                    op = pend[g][0];
                    chk("fma_a", fma_a, op.a);
                    chk("fma_b", fma_b, op.b);
                    chk("fma_c", fma_c, op.c);
                    chk("msel", msel, (op.a[14:0] == 15'd0) || (op.b[14:0] == 15'd0));
                    chk("msel_gate_off", nz_msel, 0);
                    if (msel) zg_hits++;
                    sb.push_back('{idx: g, data: op.exp});
                    acc_log.push_back(g);
                    acc_cyc.push_back(cyc);
                    acc_cnt++;
                    acc_vec = acc;
                end else begin
                    chk("idle_msel", msel, 1);
                    chk("idle_operands", {fma_a, fma_b, fma_c}, 0);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every transfer.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && rsp_valid != '0) begin
                chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                if (!stall && (rsp_valid & rsp_ready) != '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_idx", rsp_valid, 64'(1) << e.idx);
                        chk("rsp_data", rsp_data, e.data);
                    end
                end
            end
        end
    end

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", acc_cnt >= target, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic flush();
        for (int r = 0; r < NREQ; r++) pend[r].delete();
        sb.delete();
        req_valid = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn = 1'b0;
        flush();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin : main
        int base, n;
        logic [15:0] held;
        logic [NREQ-1:0] rv;
        // Reset values, with requests presented during reset
        repeat (2) @(posedge clk);
        #2;
        req_valid = '1;
        #1;
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pen", pen, 1);
        req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;

        // Single op, 1*2+3 = 5, latency 3
        @(posedge clk);
        #2;
        push(1, 16'h3C00, 16'h4000, 16'h4200, 16'h4500);
        wait_acc(1);
        @(negedge clk);
        @(negedge clk);
        chk("single_early", rsp_valid, 0);
        @(negedge clk);
        chk("single_valid", rsp_valid, 4'b0010);
        chk("single_data", rsp_data, 16'h4500);
        drain();

        // All four continuously valid from a fresh pointer
        do_reset();
        @(posedge clk);
        #2;
        base = acc_log.size();
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < NREQ; r++)
                push(r, 16'h3C00 + 16'(r), 16'h4000 + 16'(k), 16'h1000 + 16'(r*16 + k),
                     (16'h3C00 + 16'(r)) ^ (16'h4000 + 16'(k)) ^ (16'h1000 + 16'(r*16 + k)));
        wait_acc(acc_cnt + 16);
        for (int k = 0; k < 16; k++) chk("rr_order", acc_log[base+k], k % 4);
        chk("rr_back_to_back", acc_cyc[base+15] - acc_cyc[base], 15);
        drain();

        // Backpressure on requester 2
        @(posedge clk);
        #2;
        rsp_ready[2] = 1'b0;
        push(2, 16'h4400, 16'h4400, 16'h0002, 16'h4400 ^ 16'h4400 ^ 16'h0002);
        push(0, 16'h4800, 16'h3800, 16'h0010, 16'h4800 ^ 16'h3800 ^ 16'h0010);
        push(0, 16'h4801, 16'h3801, 16'h0011, 16'h4801 ^ 16'h3801 ^ 16'h0011);
        push(3, 16'h4C00, 16'h3400, 16'h0030, 16'h4C00 ^ 16'h3400 ^ 16'h0030);
        n = 0;
        while (!rsp_valid[2] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_tail", rsp_valid, 4'b0100);
        push(1, 16'h5000, 16'h3000, 16'h0040, 16'h5000 ^ 16'h3000 ^ 16'h0040);
        held = rsp_data;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_pen", pen, 0);
            chk("bp_ready", req_ready, 0);
            chk("bp_data_stable", rsp_data, held);
            chk("bp_valid_stable", rsp_valid, 4'b0100);
        end
        @(posedge clk);
        #2;
        rsp_ready[2] = 1'b1;
        drain();

        // Zero gating: -0*2+6.5 = 6.5, and a denormal that must not gate
        @(posedge clk);
        #2;
        n = zg_hits;
        push(3, 16'h8000, 16'h4000, 16'h4680, 16'h4680);
        push(0, 16'h0001, 16'h4000, 16'h3C00, 16'h0001 ^ 16'h4000 ^ 16'h3C00);
        wait_acc(acc_cnt + 2);
        drain();
        chk("zero_gate_hits", zg_hits - n, 1);

        // Global stall with three ops in flight
        @(posedge clk);
        #2;
        push(0, 16'h3C01, 16'h3C02, 16'h0100, 16'h3C01 ^ 16'h3C02 ^ 16'h0100);
        push(1, 16'h3C03, 16'h3C04, 16'h0101, 16'h3C03 ^ 16'h3C04 ^ 16'h0101);
        push(2, 16'h3C05, 16'h3C06, 16'h0102, 16'h3C05 ^ 16'h3C06 ^ 16'h0102);
        wait_acc(acc_cnt + 3);
        @(posedge clk);
        #2;
        stall = 1'b1;
        push(3, 16'h3C07, 16'h3C08, 16'h0103, 16'h3C07 ^ 16'h3C08 ^ 16'h0103);
        rv = rsp_valid;
        chk("stall_tail_present", 64'($onehot(rv)), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_pen", pen, 0);
            chk("stall_ready", req_ready, 0);
            chk("stall_rsp_frozen", rsp_valid, rv);
            chk("stall_busy", busy, 1);
        end
        @(posedge clk);
        #2;
        stall = 1'b0;
        drain();

        // Asynchronous reset with ops in flight
        @(posedge clk);
        #2;
        push(0, 16'h4000, 16'h4000, 16'h0200, 16'h4000 ^ 16'h4000 ^ 16'h0200);
        push(1, 16'h4001, 16'h4001, 16'h0201, 16'h4001 ^ 16'h4001 ^ 16'h0201);
        push(2, 16'h4002, 16'h4002, 16'h0202, 16'h4002 ^ 16'h4002 ^ 16'h0202);
        wait_acc(acc_cnt + 2);
        @(posedge clk);
        #2;
        chk("pre_reset_busy", busy, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_ready", req_ready, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        flush();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_reset_busy", busy, 0);
            chk("post_reset_rsp", rsp_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
